// File: rtl/button_debounce_pulse_if.sv
// Button conditioner bus: raw button level in, clean press pulse and debounced level out.
interface button_debounce_pulse_if;
   logic BTN;
   logic E;
   logic LEVEL;

   modport master (output BTN, input E, input LEVEL);
   modport slave  (input BTN, output E, output LEVEL);
endinterface

// File: rtl/button_debounce_pulse.sv
// Synchronizes and debounces a raw button, emitting one E pulse per accepted press plus the level.
// Optional auto-repeat while held: define DEBOUNCE_AUTOREPEAT_EN.
module button_debounce_pulse #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 16
`ifdef DEBOUNCE_AUTOREPEAT_EN
   ,
   parameter int REPEAT_CYCLES   = 8
`endif
) (
   input  logic                     CLK,
   input  logic                     RST,
   button_debounce_pulse_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state;
   logic             sync1, sync2;
   logic [CNT_W-1:0] cnt;
   logic             e_q, level_q;
`ifdef DEBOUNCE_AUTOREPEAT_EN
   localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
   logic [CNT_W-1:0] rpt;
`endif

   assign bus.E     = e_q;
   assign bus.LEVEL = level_q;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         state   <= IDLE;
         cnt     <= '0;
         e_q     <= 1'b0;
         level_q <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
         rpt     <= '0;
`endif
      end else begin
         sync1 <= bus.BTN;
         sync2 <= sync1;
         e_q   <= 1'b0;
         case (state)
            IDLE: begin
               if (sync2) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!sync2) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == DB_LAST) begin
                  state   <= PRESSED;
                  e_q     <= 1'b1;
                  level_q <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                  rpt     <= '0;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!sync2) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
`ifdef DEBOUNCE_AUTOREPEAT_EN
               // Repeat pulses only while held; rpt freezes once release starts.
               else if (rpt == RPT_LAST) begin
                  e_q <= 1'b1;
                  rpt <= '0;
               end else begin
                  rpt <= rpt + 1'b1;
               end
`endif
            end
            RELEASE_WAIT: begin
               if (sync2) begin
                  // Release bounce: back to PRESSED without a new pulse.
                  state <= PRESSED;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                  rpt   <= '0;
`endif
               end else if (cnt == DB_LAST) begin
                  state   <= IDLE;
                  level_q <= 1'b0;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state   <= IDLE;
               cnt     <= '0;
               level_q <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Scoreboard bench: stimulus pushes expected E pulse edges and LEVEL transitions; monitor checks them.
module tb_button_debounce_pulse;
   logic CLK = 1'b0;
   logic RST;
   int   edge_cnt = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   exp_e[$];
   int   lv_edge[$];
   logic lv_val[$];
   logic lv_prev = 1'b0;

   button_debounce_pulse_if bus ();

   button_debounce_pulse #(.DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   always #20 CLK = ~CLK;
   always @(posedge CLK) edge_cnt <= edge_cnt + 1;

   // Monitor: edge_cnt at a negedge equals the number of the edge that produced the outputs.
   always @(negedge CLK) begin
      if (RST === 1'b0) begin
         compared++;
         if (bus.E !== 1'b0) begin
            mismatched++;
            $display("FAIL e_in_reset: got %b want 0 at edge %0d", bus.E, edge_cnt);
         end
         compared++;
         if (bus.LEVEL !== 1'b0) begin
            mismatched++;
            $display("FAIL level_in_reset: got %b want 0 at edge %0d", bus.LEVEL, edge_cnt);
         end
      end else begin
         if (bus.E === 1'b1) begin
            compared++;
            if (exp_e.size() == 0) begin
               mismatched++;
               $display("FAIL e_unexpected: pulse at edge %0d, none expected", edge_cnt);
            end else begin
               int want;
               want = exp_e.pop_front();
               if (want != edge_cnt) begin
                  mismatched++;
                  $display("FAIL e_edge: pulse at edge %0d want edge %0d", edge_cnt, want);
               end
            end
         end
         if (bus.LEVEL !== lv_prev) begin
            compared++;
            if (lv_edge.size() == 0) begin
               mismatched++;
               $display("FAIL level_unexpected: got %b at edge %0d", bus.LEVEL, edge_cnt);
            end else begin
               int   we;
               logic wv;
               we = lv_edge.pop_front();
               wv = lv_val.pop_front();
               if (we != edge_cnt || wv !== bus.LEVEL) begin
                  mismatched++;
                  $display("FAIL level_edge: got %b at edge %0d want %b at edge %0d",
                           bus.LEVEL, edge_cnt, wv, we);
               end
            end
         end
      end
      lv_prev = bus.LEVEL;
   end

   function automatic void rep(int base, int last);
`ifdef DEBOUNCE_AUTOREPEAT_EN
      for (int k = base + 8; k <= last; k += 8) exp_e.push_back(k);
`else
      if (base > last) return;
`endif
   endfunction

   // t = first high sample edge, low first sampled at t+hold.
   function automatic void sched_press(int t, int hold);
      exp_e.push_back(t + 6);
      rep(t + 6, t + hold + 1);
      lv_edge.push_back(t + 6);        lv_val.push_back(1'b1);
      lv_edge.push_back(t + hold + 6); lv_val.push_back(1'b0);
   endfunction

   task automatic press(int hold);
      int t;
      @(negedge CLK);
      bus.BTN = 1'b1;
      t = edge_cnt + 1;
      sched_press(t, hold);
      repeat (hold) @(negedge CLK);
      bus.BTN = 1'b0;
      repeat (12) @(negedge CLK);
   endtask

   initial begin
      int t, m1, m2;
      RST = 1'b1;
      bus.BTN = 1'b1;
      #5 RST = 1'b0;

      // Reset with button held, then accepted as a fresh press.
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      t = edge_cnt + 1;
      sched_press(t, 20);
      repeat (20) @(negedge CLK);
      bus.BTN = 1'b0;
      repeat (12) @(negedge CLK);

      // Clean press.
      press(20);

      // Bounce on press: 2 high, 1 low, then held.
      @(negedge CLK);
      bus.BTN = 1'b1;
      t = edge_cnt + 4;
      sched_press(t, 16);
      repeat (2) @(negedge CLK);
      bus.BTN = 1'b0;
      @(negedge CLK);
      bus.BTN = 1'b1;
      repeat (16) @(negedge CLK);
      bus.BTN = 1'b0;
      repeat (12) @(negedge CLK);

      // Bounce on release: low 2 cycles while PRESSED, then high again.
      @(negedge CLK);
      bus.BTN = 1'b1;
      t  = edge_cnt + 1;
      m1 = t + 12;
      m2 = m1 + 2 + 12;
      exp_e.push_back(t + 6);
      rep(t + 6, m1 + 1);
      rep(m1 + 4, m2 + 1);
      lv_edge.push_back(t + 6);  lv_val.push_back(1'b1);
      lv_edge.push_back(m2 + 6); lv_val.push_back(1'b0);
      repeat (12) @(negedge CLK);
      bus.BTN = 1'b0;
      repeat (2) @(negedge CLK);
      bus.BTN = 1'b1;
      repeat (12) @(negedge CLK);
      bus.BTN = 1'b0;
      repeat (12) @(negedge CLK);

      // Reset two edges into PRESS_WAIT: aborted, then a fresh debounce.
      @(negedge CLK);
      bus.BTN = 1'b1;
      repeat (4) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      t = edge_cnt + 1;
      sched_press(t, 16);
      repeat (16) @(negedge CLK);
      bus.BTN = 1'b0;
      repeat (12) @(negedge CLK);

      // Long hold: single pulse, or repeats when auto-repeat is built in.
      press(40);
      repeat (4) @(negedge CLK);

      compared++;
      if (exp_e.size() != 0) begin
         mismatched++;
         $display("FAIL e_missing: %0d expected pulses never seen, got 0 want %0d", exp_e.size(), 0);
      end
      compared++;
      if (lv_edge.size() != 0) begin
         mismatched++;
         $display("FAIL level_missing: %0d expected transitions never seen", lv_edge.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/button_debounce_pulse.md
Name: button_debounce_pulse

Overview:
- Input conditioner directly upstream of FSM_C: turns a raw, bouncy, asynchronous push-button/switch line into a clean single-cycle pulse on E, which feeds the FSM_C E input.
- Contents: 2-flop synchronizer, counter-based debounce state machine, and registered pulse generator.
- Also exports the debounced level.
- One instance per physical input; shares CLK/RST with FSM_C.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a press or release; must be >= 1.
- CNT_W, 16, width of the debounce and repeat counters; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_CYCLES).
- REPEAT_CYCLES, 8, auto-repeat period in cycles; used only when DEBOUNCE_AUTOREPEAT_EN is defined; must be >= 1.

Ports:
- CLK  input  1  single system clock; all flops on rising edge.
- RST  input  1  reset, asynchronous assert, active-low (0 = reset); clears every flop.
- BTN  input  1  raw asynchronous button level, 1 = pressed.
- E    output 1  registered one-cycle pulse per accepted press; connects to FSM_C E.
- LEVEL output 1  registered debounced level, 1 = pressed.

Behaviour:
- Reset (RST=0, any time, independent of CLK): sync1=sync2=0, state=IDLE, cnt=0, rpt=0, E=0, LEVEL=0. All outputs are held at 0 while RST=0.
- Synchronizer: sync1<=BTN, sync2<=sync1. The FSM uses only sync2, so its view of BTN lags by 2 edges.
- States and transitions, evaluated each rising edge. E defaults to 0 every cycle unless a rule sets it.
  - IDLE: sync2=1 -> PRESS_WAIT, cnt<=0. Otherwise stay.
  - PRESS_WAIT:
    - sync2=0 -> IDLE, cnt<=0 (glitch rejected, no pulse).
    - sync2=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, E<=1, LEVEL<=1, rpt<=0.
    - Otherwise cnt<=cnt+1.
  - PRESSED: sync2=0 -> RELEASE_WAIT, cnt<=0. Otherwise stay; see optional feature.
  - RELEASE_WAIT:
    - sync2=1 -> PRESSED, rpt<=0, no E pulse (release bounce rejected).
    - sync2=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, LEVEL<=0.
    - Otherwise cnt<=cnt+1.
- Latency: BTN sampled high first at edge n and held stable. Then PRESS_WAIT is entered at edge n+2, and E=1 for exactly the one cycle following edge n+DEBOUNCE_CYCLES+2. LEVEL rises at the same edge.
- Release latency: BTN sampled low first at edge m and held. LEVEL falls at edge m+DEBOUNCE_CYCLES+2.
- Exactly one E pulse per accepted press. E is never high for 2 consecutive cycles.
- Counter compare is equality only. cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset mid-debounce aborts with no pulse. If BTN is still high after RST returns to 1, it is treated as a new press: full debounce, then one pulse.
- Illegal or unused state encodings recover to IDLE on the next edge with E=0.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined: in PRESSED with sync2=1, rpt increments each cycle. When rpt==REPEAT_CYCLES-1, E<=1 for one cycle and rpt<=0. This gives one extra pulse every REPEAT_CYCLES cycles while held. rpt is cleared on every entry to PRESSED and frozen outside PRESSED.
- Not defined: rpt logic and REPEAT_CYCLES are absent; a held button produces only the initial pulse.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, CLK period 40):
- RST=0 for 2 cycles with BTN=1 -> E=0 and LEVEL=0 throughout reset. After release, E pulses once 6 edges after the first sampling edge; LEVEL=1.
- Clean press: BTN 0->1 held 20 cycles -> E high exactly one cycle, 6 edges after first high sample; LEVEL=1. Then release held -> LEVEL=0 6 edges after first low sample, no E.
- Bounce on press: BTN 1 for 2 cycles, 0 for 1, then 1 held -> no pulse from the first burst; one E pulse 6 edges after the final rise.
- Bounce on release while PRESSED: BTN low 2 cycles then high again -> LEVEL stays 1, no additional E.
- Reset mid-debounce: RST=0 for 1 cycle, 2 edges into PRESS_WAIT -> no E. With BTN held, one pulse 6 edges after the first post-reset sample.
- With DEBOUNCE_AUTOREPEAT_EN: hold BTN 40 cycles -> initial pulse plus one pulse every 8 cycles (pulses at t0, t0+8, t0+16, ...). Without the macro -> single pulse only.
